// File: rtl/joypad_controller.sv
// Game Boy joypad front end: maps five board buttons onto the eight GB keys
// and implements the JOYP register with its high-to-low interrupt.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | center released, d-pad passes straight through
// WAIT  | center pressed, timing whether it is a tap or a hold
// TAP   | center was tapped, A held high for TAP_CYCLES clocks
// SHIFT | center held long, directions become Start/Select/B/A
module joypad_controller #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int TAP_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttonState,
    input  logic       joyp_wr,
    input  logic [7:0] joyp_wdata,
    output logic [7:0] joyp_rdata,
    output logic       irq_joypad,
    output logic [7:0] keys
);

    typedef enum logic [1:0] {IDLE, WAIT, TAP, SHIFT} state_t;

    localparam int MAX_CYCLES = (HOLD_CYCLES > TAP_CYCLES) ? HOLD_CYCLES : TAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAP_LAST  = CNT_W'(TAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] counter, cnt_nxt;
    logic [1:0]       sel;
    logic [3:0]       nib, prev;
    logic             center;
    logic [3:0]       dpad;
    logic             unused_inputs;

    assign center        = buttonState[0];
    assign dpad          = buttonState[4:1];
    assign unused_inputs = ^{buttonState[7:5], joyp_wdata[7:6], joyp_wdata[3:0]};

    // dpad order: [0]up [1]down [2]right [3]left
    function automatic logic [7:0] map_keys(input state_t st, input logic [3:0] d);
        logic [7:0] k;
        k = 8'h00;
        if (st == SHIFT) begin
            k[4] = d[2];
            k[5] = d[3];
            k[6] = d[1];
            k[7] = d[0];
        end else begin
            k[0] = d[2];
            k[1] = d[3];
            k[2] = d[0];
            k[3] = d[1];
            k[4] = (st == TAP);
        end
        return k;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = counter;
        case (state)
            IDLE: begin
                if (center) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT: begin
                // release wins over reaching the hold threshold
                if (!center) begin
                    state_nxt = TAP;
                    cnt_nxt   = '0;
                end else if (counter == HOLD_LAST) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = counter + CNT_ONE;
                end
            end
            TAP: begin
                if (counter == TAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = counter + CNT_ONE;
                end
            end
            SHIFT: begin
                if (!center) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            keys    <= 8'h00;
        end else begin
            state   <= state_nxt;
            counter <= cnt_nxt;
            keys    <= map_keys(state_nxt, dpad);
        end
    end

    // A deselected group contributes nothing; selected groups are wired-OR
    assign nib        = (sel[0] ? 4'h0 : keys[3:0]) | (sel[1] ? 4'h0 : keys[7:4]);
    assign joyp_rdata = {2'b11, sel, ~nib};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel        <= 2'b11;
            prev       <= 4'hF;
            irq_joypad <= 1'b0;
        end else begin
            if (joyp_wr) sel <= joyp_wdata[5:4];
            prev       <= ~nib;
            irq_joypad <= |(prev & nib);
        end
    end

endmodule

// File: tb/tb_joypad_controller.sv
// Scoreboard bench for joypad_controller with short hold/tap timings.
module tb_joypad_controller;

    localparam int HOLD = 8;
    localparam int TAP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buttonState;
    logic       joyp_wr;
    logic [7:0] joyp_wdata;
    logic [7:0] joyp_rdata;
    logic       irq_joypad;
    logic [7:0] keys;

    always #5 clk = ~clk;

    joypad_controller #(.HOLD_CYCLES(HOLD), .TAP_CYCLES(TAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .buttonState(buttonState),
        .joyp_wr    (joyp_wr),
        .joyp_wdata (joyp_wdata),
        .joyp_rdata (joyp_rdata),
        .irq_joypad (irq_joypad),
        .keys       (keys)
    );

    typedef struct packed {
        logic [7:0] k;
        logic [7:0] rd;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: mode 0 idle, 1 holding, 2 tapping, 3 shifted
    int         m_mode;
    int         m_hold;
    int         m_left;
    logic [7:0] m_keys;
    logic [1:0] m_sel;
    logic [3:0] m_prev;
    logic       m_irq;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [7:0] k, input logic [1:0] s);
        logic [3:0] n;
        n = 4'h0;
        if (!s[0]) n = n | k[3:0];
        if (!s[1]) n = n | k[7:4];
        return n;
    endfunction

    function automatic logic [7:0] rd_of(input logic [7:0] k, input logic [1:0] s);
        return {2'b11, s, ~nib_of(k, s)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hold = 0; m_left = 0;
        m_keys = 8'h00; m_sel = 2'b11; m_prev = 4'hF; m_irq = 1'b0;
    endtask

    task automatic model_clock(input logic [7:0] bs, input logic wr, input logic [7:0] wd);
        logic [3:0] cur;
        logic       c;
        cur    = nib_of(m_keys, m_sel);
        c      = bs[0];
        m_irq  = |(m_prev & cur);
        m_prev = ~cur;
        if (wr) m_sel = wd[5:4];
        case (m_mode)
            0: if (c) begin m_mode = 1; m_hold = 1; end
            1: begin
                if (!c) begin m_mode = 2; m_left = TAP; end
                else if (m_hold == HOLD - 1) m_mode = 3;
                else m_hold++;
            end
            2: begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            default: if (!c) m_mode = 0;
        endcase
        if (m_mode == 3)
            m_keys = {bs[1], bs[2], bs[4], bs[3], 4'h0};
        else
            m_keys = {3'b000, (m_mode == 2), bs[2], bs[1], bs[4], bs[3]};
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check("keys", keys, e.k);
        check("rdata", joyp_rdata, e.rd);
        check("irq", {7'b0, irq_joypad}, {7'b0, e.irq});
    endtask

    task automatic drive(input logic [7:0] bs, input logic wr, input logic [7:0] wd);
        exp_t e;
        @(negedge clk);
        buttonState = bs;
        joyp_wr     = wr;
        joyp_wdata  = wd;
        model_clock(bs, wr, wd);
        e.k = m_keys; e.rd = rd_of(m_keys, m_sel); e.irq = m_irq;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic step(input logic [7:0] bs);
        drive(bs, 1'b0, 8'h00);
    endtask

    task automatic write_sel(input logic [7:0] wd, input logic [7:0] bs);
        drive(bs, 1'b1, wd);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        buttonState = 8'h00;
        joyp_wr     = 1'b0;
        reset       = 1'b1;
        #1;
        model_reset();
        e.k = 8'h00; e.rd = 8'hFF; e.irq = 1'b0;
        sb.push_back(e);
        compare_out();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int a_hi;
        int n_irq;
        reset = 1'b1; buttonState = 8'h00; joyp_wr = 1'b0; joyp_wdata = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", joyp_rdata, 8'hFF);
        check("rst_keys", keys, 8'h00);
        check("rst_irq", {7'b0, irq_joypad}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step(8'h00);
        step(8'h00);

        // d-pad group, press and release up
        write_sel(8'h20, 8'h00);
        step(8'h02);
        check("up_keys", keys, 8'h04);
        check("up_rdata", joyp_rdata, 8'hEB);
        step(8'h02);
        check("up_irq", {7'b0, irq_joypad}, 8'h01);
        step(8'h02);
        step(8'h00);
        check("rel_rdata", joyp_rdata, 8'hEF);
        step(8'h00);
        check("rel_irq", {7'b0, irq_joypad}, 8'h00);

        // button group, center tap
        write_sel(8'h10, 8'h00);
        a_hi = 0; n_irq = 0;
        for (int i = 0; i < 12; i++) begin
            step((i < 3) ? 8'h01 : 8'h00);
            a_hi  += int'(keys[4]);
            n_irq += int'(irq_joypad);
            if (i == 3) check("tap_nib", {4'h0, joyp_rdata[3:0]}, 8'h0E);
        end
        check("tap_len", 8'(a_hi), 8'd4);
        check("tap_irqs", 8'(n_irq), 8'd1);
        check("tap_end_nib", {4'h0, joyp_rdata[3:0]}, 8'h0F);

        // hold into SHIFT, press down
        for (int i = 0; i < 10; i++) step(8'h01);
        step(8'h05);
        check("shift_down", keys, 8'h40);
        step(8'h00);
        check("shift_exit", keys, 8'h00);
        step(8'h00);

        // release exactly at the hold threshold still counts as a tap
        for (int i = 0; i < 7; i++) step(8'h01);
        step(8'h00);
        check("edge_tap", keys, 8'h10);
        step(8'h01);
        step(8'h01);
        step(8'h01);
        check("tap_ignore_c", keys, 8'h10);
        for (int i = 0; i < 4; i++) step(8'h00);

        // both groups selected: wired-OR
        write_sel(8'h00, 8'h00);
        for (int i = 0; i < 9; i++) step(8'h01);
        step(8'h03);
        check("shift_start", keys, 8'h80);
        check("wired_or", joyp_rdata, 8'hC7);

        // reset mid-SHIFT then mid-TAP
        do_reset();
        step(8'h00);
        step(8'h01);
        step(8'h01);
        step(8'h00);
        step(8'h00);
        do_reset();
        step(8'h00);

        // random stimulus against the model
        for (int i = 0; i < 300; i++) begin
            logic [7:0] bs;
            bs = 8'($urandom);
            if ($urandom_range(0, 3) != 0) bs[0] = bs[0] | (i[5] ^ i[2]);
            if ($urandom_range(0, 15) == 0)
                write_sel(8'($urandom), bs);
            else
                step(bs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
